// File: rtl/alu_muldiv_pkg.sv
// Shared opcode encodings, FSM states and operand-signedness helpers for the M-extension unit.
package alu_muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == MULH) || (f == DIV) || (f == REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// Combinational operand conditioning: magnitudes, sign flags, divide-by-zero and signed-overflow detection.
// Zero latency; no handshake, sampled by the parent only when a request is accepted.
module muldiv_operand_cond
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            sign_a,
    output logic            sign_b,
    output logic            div_zero,
    output logic            div_ovf
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        sign_a   = is_signed_a(funct3) & a[XLEN-1];
        sign_b   = is_signed_b(funct3) & b[XLEN-1];
        mag_a    = sign_a ? -a : a;
        mag_b    = sign_b ? -b : b;
        div_zero = funct3[2] & (b == '0);
        // Only DIV and REM (funct3[0]=0) are signed divides.
        div_ovf  = funct3[2] & ~funct3[0] & (a == INT_MIN) & (b == '1);
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// XLEN+2 cycles request-to-done (2 for div-by-zero/overflow); start ignored while busy, flush aborts.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   dvsr;
    logic [2:0]        op;
    logic              sign_a_q, sign_b_q, special_q;
    logic [XLEN-1:0]   spec_res_q;

    logic [XLEN-1:0]   mag_a, mag_b;
    logic              sign_a, sign_b, div_zero, div_ovf;

    muldiv_operand_cond #(.XLEN(XLEN)) u_cond (
        .funct3   (funct3),
        .a        (a),
        .b        (b),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .div_zero (div_zero),
        .div_ovf  (div_ovf)
    );

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    logic [XLEN:0]     add_sum, rem_shift, diff;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff      = rem_shift - {1'b0, dvsr};
        if (op[2]) begin
            acc_next = diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc : acc;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            MUL:                 fix_res = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quo_fix;
            default:             fix_res = rem_fix;
        endcase
        if (special_q) fix_res = spec_res_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            dvsr       <= '0;
            op         <= MUL;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op         <= funct3;
                        sign_a_q   <= sign_a;
                        sign_b_q   <= sign_b;
                        acc        <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                        dvsr       <= funct3[2] ? mag_b : mag_a;
                        cnt        <= '0;
                        special_q  <= div_zero | div_ovf;
                        // Div-by-zero: quotient all ones, remainder a. Overflow: quotient a, remainder 0.
                        spec_res_q <= div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
                        busy       <= 1'b1;
                        state      <= (div_zero | div_ovf) ? FIX : CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq (XLEN=32 main instance, XLEN=64 for the wide multiply case).
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        start64;
    logic [2:0]  funct3_64;
    logic [63:0] a64, b64;
    logic        busy64, done64;
    logic [63:0] result64;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] exp64_q[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    alu_muldiv_seq #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .flush(1'b0), .funct3(funct3_64),
        .a(a64), .b(b64), .busy(busy64), .done(done64), .result(result64)
    );

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 32'h0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] model32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = {32'h0, x} * {32'h0, y}; return p[31:0]; end
            3'b001: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
            3'b010: begin p = $signed({{32{x[31]}}, x}) * $signed({32'h0, y}); return p[63:32]; end
            3'b011: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                return $signed(x) / $signed(y);
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Drives a request that is sampled at the next rising edge; returns at that edge + 1.
    task automatic start_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit push);
        funct3 = f; a = x; b = y; start = 1'b1;
        if (push) begin
            exp_q.push_back(model32(f, x, y));
            lat_q.push_back(is_special(f, x, y) ? 2 : 34);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int bc0, input string name);
        int n = n0;
        int bc = bc0;
        logic [31:0] e;
        int l;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty: got result %h", name, result);
        end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            last_res = e;
            checks++;
            if (result !== e) begin
                errors++; $display("FAIL %s result: got %h required %h", name, result, e);
            end
            checks++;
            if (n != l) begin
                errors++; $display("FAIL %s latency: got %0d required %0d", name, n, l);
            end
            checks++;
            if (bc != l - 1) begin
                errors++; $display("FAIL %s busy cycles: got %0d required %0d", name, bc, l - 1);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL %s busy at done: got %b required 0", name, busy);
            end
        end
    endtask

    task automatic check_idle_after(input string name);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== last_res) begin
            errors++; $display("FAIL %s hold: done=%b result=%h required done=0 result=%h", name, done, result, last_res);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = '0; b = '0;
        start64 = 1'b0; funct3_64 = 3'b000; a64 = '0; b64 = '0;
        last_res = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset32: busy=%b done=%b result=%h required 0/0/0", busy, done, result);
        end
        checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || result64 !== 64'h0) begin
            errors++; $display("FAIL reset64: busy=%b done=%b result=%h required 0/0/0", busy64, done64, result64);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL post_reset idle: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_mul();
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1);
        wait_done(1, int'(busy), "mul_7_m3");
        check_idle_after("mul_7_m3");
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done(1, int'(busy), "mulhu");
        start_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done(1, int'(busy), "mulhsu");
        start_op(3'b001, 32'hFFFF_FFF9, 32'h0001_0003, 1);
        wait_done(1, int'(busy), "mulh");
    endtask

    task automatic test_div();
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(1, int'(busy), "div_m7_2");
        start_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(1, int'(busy), "rem_m7_2");
        start_op(3'b101, 32'd100, 32'd7, 1);
        wait_done(1, int'(busy), "divu_100_7");
        start_op(3'b111, 32'd100, 32'd7, 1);
        wait_done(1, int'(busy), "remu_100_7");
    endtask

    task automatic test_special();
        start_op(3'b100, 32'd1234, 32'd0, 1);
        wait_done(1, int'(busy), "div_by_zero");
        check_idle_after("div_by_zero");
        start_op(3'b110, 32'd1234, 32'd0, 1);
        wait_done(1, int'(busy), "rem_by_zero");
        start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(1, int'(busy), "div_overflow");
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(1, int'(busy), "rem_overflow");
    endtask

    task automatic test_flush();
        int dn = 0;
        start_op(3'b100, 32'd1000, 32'd3, 0);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1; start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush idle: busy=%b done=%b required 0/0", busy, done);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 0 || result !== last_res) begin
            errors++; $display("FAIL flush no_done: done pulses=%0d result=%h required 0 and %h", dn, result, last_res);
        end
    endtask

    task automatic test_start_ignored();
        int n = 1;
        int bc;
        start_op(3'b101, 32'd1000, 32'd7, 1);
        bc = int'(busy);
        for (int i = 0; i < 8; i++) begin
            start = (i >= 3 && i < 6); funct3 = 3'b000; a = 32'd5; b = 32'd5;
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        start = 1'b0;
        wait_done(n, bc, "start_ignored");
    endtask

    task automatic test_back_to_back();
        start_op(3'b000, 32'd12345, 32'd678, 1);
        wait_done(1, int'(busy), "b2b_first");
        start_op(3'b101, 32'hDEAD_BEEF, 32'd17, 1);
        wait_done(1, int'(busy), "b2b_second");
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(1, int'(busy), "b2b_special");
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        start_op(3'b000, 32'd123, 32'd456, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b result=%h required 0/0/0", busy, done, result);
        end
        last_res = 32'h0;
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid no_done: done pulses=%0d busy=%b required 0/0", dn, busy);
        end
        start_op(3'b111, 32'hFFFF_FFF0, 32'd9, 1);
        wait_done(1, int'(busy), "after_reset");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            start_op(f, x, y, 1);
            wait_done(1, int'(busy), "random");
        end
    endtask

    task automatic test_mul64();
        logic [63:0] xs[2];
        logic [63:0] ys[2];
        logic [2:0]  fs[2];
        logic [127:0] p;
        logic [63:0] e;
        int n;
        xs[0] = 64'd7;                  ys[0] = 64'hFFFF_FFFF_FFFF_FFFD; fs[0] = 3'b000;
        xs[1] = 64'hFFFF_FFFF_FFFF_FFFF; ys[1] = 64'hFFFF_FFFF_FFFF_FFFF; fs[1] = 3'b011;
        for (int k = 0; k < 2; k++) begin
            p = {64'h0, xs[k]} * {64'h0, ys[k]};
            exp64_q.push_back(fs[k] == 3'b000 ? p[63:0] : p[127:64]);
            funct3_64 = fs[k]; a64 = xs[k]; b64 = ys[k]; start64 = 1'b1;
            @(posedge clk); #1;
            start64 = 1'b0;
            n = 1;
            while (!done64 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            e = exp64_q.pop_front();
            checks++;
            if (done64 !== 1'b1 || n != 66) begin
                errors++; $display("FAIL mul64[%0d] latency: done=%b cycles=%0d required 1 and 66", k, done64, n);
            end
            checks++;
            if (result64 !== e) begin
                errors++; $display("FAIL mul64[%0d] result: got %h required %h", k, result64, e);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_mul64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative multiply/divide unit for the RV32M/RV64M extension, parametrised in operand width. It sits beside the single-cycle ALU and takes the same funct3 field that the ALU decoder consumes when the opcode selects the M extension. It runs a start/busy/done handshake and stalls the core while an operation is in flight. One result is produced per operation: shift-add for multiply, restoring division for divide/remainder.

## Interface
- XLEN, default 32: operand and result width. Legal values are 32 and 64.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- flush  input  1  abort the current operation; has priority over start
- funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand (multiplicand / dividend)
- b  input  XLEN  rs2 operand (multiplier / divisor)
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  final result; held stable from done until the next accepted start

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - FIX: sign correction and selection of the result half.
  - DONE: done=1 for exactly one cycle.
- When start=1 in IDLE or DONE, the unit latches funct3, a and b and goes to CALC.
- Operand conditioning:
  - Signed operands are converted to magnitudes. Signedness follows funct3: a is signed for MULH, MULHSU, DIV and REM; b is signed for MULH, DIV and REM.
  - The result sign is recorded.
- Multiply: a 2·XLEN product register, shift-add, one multiplier bit per cycle.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits after sign correction.
- Divide: restoring division, one quotient bit per cycle.
  - The quotient takes the sign of a XOR b.
  - The remainder takes the sign of a.
- Special cases skip CALC and go directly to FIX:
  - Divisor 0: DIV and DIVU return all ones; REM and REMU return a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): DIV returns a; REM returns 0.
- CALC uses an iteration counter of width $clog2(XLEN)+1 that counts XLEN iterations and then moves to FIX.
- FIX writes result and moves to DONE. DONE returns to IDLE unless start=1, which is accepted back-to-back.
- start is ignored in CALC and FIX.
- flush=1 in any state goes to IDLE on the next edge, with no done pulse. result keeps its previous value.
- All internal arithmetic is done at XLEN+1 or 2·XLEN bits. There is no truncation before FIX.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0.
- Reset asserted mid-operation ends the operation immediately. No done pulse is produced.
- Normal latency: start sampled at edge 0; busy is high from edge 0; FIX is at edge XLEN; done is high for the cycle after edge XLEN+1. That is XLEN+2 cycles from request to done.
- Special-case latency: done is high for the cycle after edge 1 (2 cycles).
- busy falls in the same cycle that done rises.
- All outputs are registered. There is no combinational path from any input to any output.
- When flush and start are high in the same cycle, flush wins.

## Structure
- Package alu_muldiv_pkg holds:
  - the funct3 localparams (MUL … REMU)
  - the state enum (IDLE, CALC, FIX, DONE)
  - the helper function is_signed_a/b(funct3)
- One sub-module, muldiv_operand_cond. It is combinational and computes the magnitudes, the sign flags and the special-case detection for a and b.
- The state machine, the iteration datapath and the result mux stay in the top module.

## Test plan
- MUL, XLEN=32, a=7, b=−3 → done at cycle 34 with result 0xFFFFFFEB; busy high for cycles 0–33.
- MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF → result 0xFFFFFFFE. MULHSU, a=−1, b=0xFFFFFFFF → result 0xFFFFFFFF.
- DIV and REM, a=−7, b=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU, a=100, b=7 → 14. REMU, same operands → 2.
- Special cases, each with done at cycle 2:
  - DIV, b=0 → 0xFFFFFFFF.
  - REM, b=0 → a.
  - DIV, a=0x80000000, b=−1 → 0x80000000.
  - REM, same operands → 0.
- flush asserted at cycle 10 of a DIV → IDLE next cycle, no done, result unchanged. start asserted during CALC is ignored. start in DONE starts a second operation whose done comes 34 cycles later.
- reset_n pulled low mid-CALC → busy=0, done=0, result=0 asynchronously. The first operation after release completes normally. Repeat the MUL case with XLEN=64: done at cycle 66.
